// File: rtl/load_extend_ctrl.sv
// rtl/load_extend_ctrl.sv - single-outstanding MIPS load sequencer with lane select and extension

// Widens an IN_W-bit value to OUT_W bits, replicating the MSB when is_signed is set.
module sign_extend #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  data,
    input  logic             is_signed,
    output logic [OUT_W-1:0] result
);

    // Fill the upper bits with the sign bit or with zeros.
    always_comb begin
        result = {{(OUT_W-IN_W){is_signed & data[IN_W-1]}}, data};
    end

endmodule

module load_extend_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] lane_q;
    logic [1:0] size_q;
    logic       unsigned_q;

    logic                  req_bad;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [DATA_WIDTH-1:0] byte_ext;
    logic [DATA_WIDTH-1:0] half_ext;
    logic [DATA_WIDTH-1:0] load_result;

    // Illegal size or a half/word request whose low address bits break natural alignment.
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            SIZE_BYTE: req_bad = 1'b0;
            SIZE_HALF: req_bad = req_addr[0];
            SIZE_WORD: req_bad = |req_addr[1:0];
            default:   req_bad = 1'b1;
        endcase
    end

    // Little-endian lane pick from the returned word using the captured low address bits.
    always_comb begin
        byte_lane = mem_rd_data[8*lane_q +: 8];
        half_lane = lane_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
    end

    sign_extend #(.IN_W(8), .OUT_W(DATA_WIDTH)) u_ext_byte (
        .data      (byte_lane),
        .is_signed (~unsigned_q),
        .result    (byte_ext)
    );

    sign_extend #(.IN_W(16), .OUT_W(DATA_WIDTH)) u_ext_half (
        .data      (half_lane),
        .is_signed (~unsigned_q),
        .result    (half_ext)
    );

    // Choose the extended lane by access size; word loads pass straight through.
    always_comb begin
        load_result = mem_rd_data;
        case (size_q)
            SIZE_BYTE: load_result = byte_ext;
            SIZE_HALF: load_result = half_ext;
            default:   load_result = mem_rd_data;
        endcase
    end

    // Request/read/capture/response sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            lane_q     <= 2'b00;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lane_q     <= req_addr[1:0];
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        req_ready  <= 1'b0;
                        if (req_bad) begin
                            // Rejected requests never touch memory.
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                            state      <= RESP;
                        end else begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            state     <= READ;
                        end
                    end
                end
                READ: begin
                    mem_rd_en <= 1'b0;
                    state     <= CAPTURE;
                end
                CAPTURE: begin
                    resp_data  <= load_result;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_extend_ctrl.sv
// tb/tb_load_extend_ctrl.sv - directed self-checking bench for load_extend_ctrl
module tb_load_extend_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rd_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    int n_vec;
    int n_bad;
    int strobes;

    load_extend_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_err     (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns the word the cycle after a strobe and zero otherwise.
    always @(posedge clk) begin
        if (mem_rd_en)
            mem_rd_data <= (mem_addr == 32'h100) ? 32'h8001F0A5 : 32'hDEADBEEF;
        else
            mem_rd_data <= 32'h0;
        if (mem_rd_en)
            strobes <= strobes + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  req_ready,  32'd1);
        check({tag, "_mem_rd_en"},  mem_rd_en,  32'd0);
        check({tag, "_mem_addr"},   mem_addr,   32'd0);
        check({tag, "_resp_valid"}, resp_valid, 32'd0);
        check({tag, "_resp_data"},  resp_data,  32'd0);
        check({tag, "_resp_err"},   resp_err,   32'd0);
    endtask

    // Called #1 after a rising edge; returns #1 after the accept edge (cycle N+1).
    task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic u);
        req_valid    = 1'b1;
        req_addr     = a;
        req_size     = s;
        req_unsigned = u;
        check("req_ready_idle", req_ready, 32'd1);
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_addr     = 32'hFFFF_FFFF;
        req_size     = 2'b11;
        req_unsigned = ~u;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] s, input logic u,
                           input logic [31:0] exp_d, input logic exp_e);
        int s0;
        s0 = strobes;
        issue(a, s, u);
        if (!exp_e) begin
            check("n1_mem_rd_en", mem_rd_en, 32'd1);
            check("n1_mem_addr", mem_addr, {a[31:2], 2'b00});
            check("n1_resp_valid", resp_valid, 32'd0);
            @(posedge clk); #1;
            check("n2_mem_rd_en", mem_rd_en, 32'd0);
            check("n2_resp_valid", resp_valid, 32'd0);
            @(posedge clk); #1;
        end else begin
            check("err_mem_rd_en", mem_rd_en, 32'd0);
        end
        check("resp_valid", resp_valid, 32'd1);
        check("resp_data", resp_data, exp_d);
        check("resp_err", resp_err, {31'd0, exp_e});
        check("req_ready_busy", req_ready, 32'd0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("post_resp_valid", resp_valid, 32'd0);
        check("post_req_ready", req_ready, 32'd1);
        check("strobe_count", strobes - s0, exp_e ? 32'd0 : 32'd1);
    endtask

    initial begin
        logic [31:0] held_d;
        int s0;
        n_vec = 0; n_bad = 0; strobes = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_size = 2'b00;
        req_unsigned = 1'b0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_load(32'h100, 2'b00, 1'b0, 32'hFFFFFFA5, 1'b0);
        do_load(32'h101, 2'b00, 1'b1, 32'h000000F0, 1'b0);
        do_load(32'h103, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
        do_load(32'h102, 2'b00, 1'b1, 32'h00000001, 1'b0);
        do_load(32'h102, 2'b01, 1'b0, 32'hFFFF8001, 1'b0);
        do_load(32'h102, 2'b01, 1'b1, 32'h00008001, 1'b0);
        do_load(32'h100, 2'b01, 1'b0, 32'hFFFFF0A5, 1'b0);
        do_load(32'h100, 2'b10, 1'b0, 32'h8001F0A5, 1'b0);
        do_load(32'h100, 2'b10, 1'b1, 32'h8001F0A5, 1'b0);
        do_load(32'h103, 2'b01, 1'b0, 32'h00000000, 1'b1);
        do_load(32'h102, 2'b10, 1'b0, 32'h00000000, 1'b1);
        do_load(32'h100, 2'b11, 1'b0, 32'h00000000, 1'b1);

        // Back-pressure: response held for five cycles with resp_ready low.
        s0 = strobes;
        issue(32'h101, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("stall_valid0", resp_valid, 32'd1);
        held_d = resp_data;
        check("stall_data0", held_d, 32'hFFFFFFF0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_valid", resp_valid, 32'd1);
            check("stall_data", resp_data, 32'hFFFFFFF0);
            check("stall_err", resp_err, 32'd0);
            check("stall_req_ready", req_ready, 32'd0);
            check("stall_rd_en", mem_rd_en, 32'd0);
        end
        check("stall_strobes", strobes - s0, 32'd1);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("stall_release_ready", req_ready, 32'd1);
        check("stall_release_valid", resp_valid, 32'd0);

        // Reset while the read strobe is out.
        issue(32'h100, 2'b00, 1'b0);
        check("pre_rst_rd_en", mem_rd_en, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_read");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("aborted_no_resp", resp_valid, 32'd0);
            check("aborted_req_ready", req_ready, 32'd1);
        end

        // Reset while a response is pending.
        issue(32'h103, 2'b00, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_resp_valid", resp_valid, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_resp");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_load(32'h102, 2'b01, 1'b0, 32'hFFFF8001, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
